bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word to transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 en  input  1  shift enable; 0 stalls the serial output.
REQ-009 o  output  1  serial bit; feeds the downstream 0110 pattern detector input.
REQ-010 o_valid  output  1  o carries a data bit this cycle.
REQ-011 last  output  1  o carries the final bit of the current word.

Function
REQ-012 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; din_valid with din_ready=0 SHALL be ignored.
REQ-013 Datapath: WIDTH-bit shift register sr, bit counter cnt, one-entry holding register hold with flag hold_full.
REQ-014 FSM states: IDLE (sr empty) and SHIFT (sr holds a word being emitted).
REQ-015 "Shifter free" at an edge means state=IDLE, or state=SHIFT with en=1 and cnt=WIDTH-1.
REQ-016 din_ready SHALL equal !hold_full, decoded from registered state only; it SHALL have no combinational path from din_valid or en.
REQ-017 On a transfer with the shifter free and hold empty: word loads into sr, cnt<=0, state<=SHIFT.
REQ-018 On a transfer with the shifter not free: word loads into hold, hold_full<=1.
REQ-019 With the shifter free and hold_full=1: hold moves to sr, cnt<=0, state<=SHIFT, hold_full<=0.
REQ-020 With the shifter free and no word available: state<=IDLE.
REQ-021 In SHIFT with en=1 and cnt<WIDTH-1: sr shifts one position toward the output end, cnt<=cnt+1.
REQ-022 In SHIFT with en=0: sr, cnt and state SHALL hold; transfers into an empty hold SHALL still occur.
REQ-023 o SHALL be sr[WIDTH-1] when MSB_FIRST=1, else sr[0], in SHIFT; o SHALL be 0 in IDLE.
REQ-024 o_valid SHALL be 1 iff state=SHIFT; last SHALL be 1 iff state=SHIFT and cnt=WIDTH-1.
REQ-025 Latency: a word transferred into an empty block at edge E SHALL present its first bit on o in the cycle after E.
REQ-026 With en=1 and continuous din_valid=1, the output SHALL be gapless: o_valid stays 1 across word boundaries.
REQ-027 cnt width SHALL be clog2(WIDTH); cnt SHALL never exceed WIDTH-1 and SHALL not wrap.

Reset
REQ-028 rst_b=0 SHALL immediately force state=IDLE, cnt=0, sr=0, hold=0, hold_full=0.
REQ-029 During reset, outputs SHALL be o=0, o_valid=0, last=0 and din_ready=1.
REQ-030 Reset asserted mid-word SHALL discard the partial word and any held word; no bits of either SHALL appear after release.
REQ-031 The first transfer SHALL be possible on the first rising edge after rst_b deasserts.

Structure
REQ-032 Shared package SHALL hold the state encoding (IDLE, SHIFT) and the WIDTH default.
REQ-033 The holding register with its full flag SHALL be a sub-module named ser_hold_buf; sr, cnt and the FSM stay in bit_serializer.

Verification
REQ-034 Reset, then din=8'h36 for one cycle with en=1 -> o = 0,0,1,1,0,1,1,0 on 8 consecutive cycles; last=1 on the 8th only; then o_valid=0 and o=0.
REQ-035 Back-to-back transfer of 8'hA5 then 8'h3C, en=1 -> 16 contiguous valid bits 10100101 00111100; din_ready=0 while hold is full.
REQ-036 en=0 for 3 cycles after bit 3 of 8'hF0 -> o, o_valid and cnt hold for 3 cycles, then the remaining bits resume; no bit is lost or duplicated.
REQ-037 rst_b pulsed low at bit 4 of 8'hFF with a second word held -> o=0, o_valid=0 and din_ready=1 immediately; no further bits of either word appear.
REQ-038 MSB_FIRST=0 with din=8'h01 -> o = 1,0,0,0,0,0,0,0.
REQ-039 Serializer output chained into the 0110 pattern detector, din=8'h66 -> detector output asserts twice, one cycle after each 0110 completes.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding and default word width.
package bit_serializer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle; master drives words and enable, slave serializes.
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             en;
    logic             o;
    logic             o_valid;
    logic             last;

    modport master (
        output din, din_valid, en,
        input  din_ready, o, o_valid, last
    );

    modport slave (
        input  din, din_valid, en,
        output din_ready, o, o_valid, last
    );

endinterface

// File: rtl/bit_serializer_hold_buf.sv
// One-entry holding register that parks the next word while the shifter is busy.
module ser_hold_buf
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // A write only happens while empty and a read only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_data <= i_din;
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer with a one-word skid buffer so back-to-back words stream without gaps.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    bit_serializer_if.slave  bus
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_full;
    logic             w_free;
    logic             w_xfer;
    logic             w_hold_wr;
    logic             w_hold_rd;

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) shift_word = {w[WIDTH-2:0], 1'b0};
        else                shift_word = {1'b0, w[WIDTH-1:1]};
    endfunction

    // Shifter is free when idle, or when the final bit is leaving this edge.
    assign w_free    = (r_state == ST_IDLE) || (bus.en && (r_cnt == CNT_LAST));
    assign w_xfer    = bus.din_valid && !w_hold_full;
    assign w_hold_wr = w_xfer && !w_free;
    assign w_hold_rd = w_free && w_hold_full;

    ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst_b  (rst_b),
        .i_wr   (w_hold_wr),
        .i_din  (bus.din),
        .i_rd   (w_hold_rd),
        .o_data (w_hold_data),
        .o_full (w_hold_full)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else if (w_free) begin
            if (w_hold_full) begin
                r_sr    <= w_hold_data;
                r_cnt   <= '0;
                r_state <= ST_SHIFT;
            end else if (w_xfer) begin
                r_sr    <= bus.din;
                r_cnt   <= '0;
                r_state <= ST_SHIFT;
            end else begin
                r_state <= ST_IDLE;
            end
        end else if (bus.en) begin
            r_sr  <= shift_word(r_sr);
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Ready depends only on the registered hold flag, never on din_valid or en.
    assign bus.din_ready = !w_hold_full;
    assign bus.o_valid   = (r_state == ST_SHIFT);
    assign bus.o         = (r_state == ST_SHIFT) &&
                           ((MSB_FIRST != 0) ? r_sr[WIDTH-1] : r_sr[0]);
    assign bus.last      = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer against a word-queue reference model.
module tb_bit_serializer;

    localparam int W = 8;

    logic clk;
    logic rst_b;

    bit_serializer_if #(.WIDTH(W)) m_if ();
    bit_serializer_if #(.WIDTH(W)) l_if ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (m_if)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (l_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference: words still owed to the output, and how many bits of the head word are already out.
    logic [W-1:0] wq[$];
    int           pos = 0;
    logic [3:0]   det = 4'b1111;
    int           hits = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic         ev, eo, el, er, xfer;
        logic [W-1:0] head;
        @(negedge clk);
        ev = (wq.size() > 0);
        eo = 1'b0;
        el = 1'b0;
        if (ev) begin
            head = wq[0];
            eo   = head[W-1-pos];
            el   = (pos == W - 1);
        end
        er = (wq.size() < 2);
        chk("o",         m_if.o,         eo);
        chk("o_valid",   m_if.o_valid,   ev);
        chk("last",      m_if.last,      el);
        chk("din_ready", m_if.din_ready, er);
        if (m_if.o_valid) begin
            det = {det[2:0], m_if.o};
            if (det == 4'b0110) hits++;
        end
        xfer = m_if.din_valid && er;
        @(posedge clk);
        if (rst_b) begin
            if (ev && m_if.en) begin
                if (pos == W - 1) begin
                    void'(wq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (xfer) wq.push_back(m_if.din);
        end
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        m_if.din       = w;
        m_if.din_valid = 1'b1;
        cycle();
        m_if.din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_pos(input int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 40) begin
            cycle();
            guard++;
        end
        chk("reach_pos", pos, p);
    endtask

    task automatic lsb_word(input logic [W-1:0] w);
        l_if.din       = w;
        l_if.din_valid = 1'b1;
        @(posedge clk);
        #1;
        l_if.din_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("lsb_o",     l_if.o,       w[k]);
            chk("lsb_valid", l_if.o_valid, 1'b1);
            chk("lsb_last",  l_if.last,    (k == W - 1));
        end
        @(negedge clk);
        chk("lsb_idle", l_if.o_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b          = 1'b0;
        m_if.din       = '0;
        m_if.din_valid = 1'b0;
        m_if.en        = 1'b1;
        l_if.din       = '0;
        l_if.din_valid = 1'b0;
        l_if.en        = 1'b1;
        #1;
        chk("rst_o",       m_if.o,         1'b0);
        chk("rst_o_valid", m_if.o_valid,   1'b0);
        chk("rst_last",    m_if.last,      1'b0);
        chk("rst_ready",   m_if.din_ready, 1'b1);
        idle(2);

        // Word presented as reset releases must transfer on the very next edge.
        m_if.din       = 8'h36;
        m_if.din_valid = 1'b1;
        rst_b          = 1'b1;
        cycle();
        m_if.din_valid = 1'b0;
        chk("first_xfer", wq.size(), 1);
        idle(10);

        send(8'hA5);
        send(8'h3C);
        idle(20);

        send(8'hF0);
        run_to_pos(3);
        m_if.en = 1'b0;
        idle(3);
        m_if.en = 1'b1;
        idle(12);

        send(8'hFF);
        send(8'h81);
        run_to_pos(4);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_o",       m_if.o,         1'b0);
        chk("mid_rst_o_valid", m_if.o_valid,   1'b0);
        chk("mid_rst_last",    m_if.last,      1'b0);
        chk("mid_rst_ready",   m_if.din_ready, 1'b1);
        wq.delete();
        pos = 0;
        idle(2);
        rst_b = 1'b1;
        idle(12);

        det  = 4'b1111;
        hits = 0;
        send(8'h66);
        idle(12);
        chk("det_hits", hits, 2);

        for (int i = 0; i < 400; i++) begin
            m_if.din       = W'($urandom);
            m_if.din_valid = ($urandom_range(0, 3) != 0);
            m_if.en        = ($urandom_range(0, 4) != 0);
            cycle();
        end
        m_if.din_valid = 1'b0;
        m_if.en        = 1'b1;
        idle(24);

        lsb_word(8'h01);
        lsb_word(W'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
